mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the memory.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the memory together.
interface mem_arbiter_if;
  // Instruction-fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  // Data load/store port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_func3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // Single-ported memory side
  logic        memory_wen;
  logic [31:0] memory_ra;
  logic [31:0] memory_wa;
  logic [31:0] memory_wd;
  logic [2:0]  memory_func3;
  logic [31:0] memory_rd;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_func3,
    output d_gnt, d_rvalid, d_rdata,
    output memory_wen, memory_ra, memory_wa, memory_wd, memory_func3,
    input  memory_rd
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_func3,
    input  d_gnt, d_rvalid, d_rdata,
    input  memory_wen, memory_ra, memory_wa, memory_wd, memory_func3,
    output memory_rd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Data accesses normally win over instruction fetch.
// A saturating starvation counter forces fetch to win after MAX_WAIT lost cycles.
// Grants are combinational. Read data comes back one cycle later and is steered
// to the owner of the previous cycle's read.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  // A zero MAX_WAIT would leave no counter bits, so keep at least one bit.
  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  // Owner of the read whose data returns this cycle
  localparam logic [1:0] StNone = 2'd0;
  localparam logic [1:0] StRdIf = 2'd1;
  localparam logic [1:0] StRdD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_win, data_win;

  // Arbitration. Grants are masked while reset is held so that all outputs read 0.
  always_comb begin
    fetch_win = rst_n & bus.if_req & (~bus.d_req | (wait_cnt_q == WaitMax));
    data_win  = rst_n & bus.d_req & ~fetch_win;
  end

  // Grant and memory command outputs. Everything is 0 in a cycle without a grant.
  always_comb begin
    bus.if_gnt       = 1'b0;
    bus.d_gnt        = 1'b0;
    bus.memory_wen   = 1'b0;
    bus.memory_ra    = 32'h0;
    bus.memory_wa    = 32'h0;
    bus.memory_wd    = 32'h0;
    bus.memory_func3 = 3'b000;
    if (fetch_win) begin
      bus.if_gnt       = 1'b1;
      bus.memory_ra    = bus.if_addr;
      bus.memory_func3 = 3'b010;
    end else if (data_win) begin
      bus.d_gnt        = 1'b1;
      bus.memory_func3 = bus.d_func3;
      if (bus.d_we) begin
        bus.memory_wen = 1'b1;
        bus.memory_wa  = bus.d_addr;
        bus.memory_wd  = bus.d_wdata;
      end else begin
        bus.memory_ra  = bus.d_addr;
      end
    end
  end

  // Next read owner and the starvation counter
  always_comb begin
    state_d = StNone;
    if (fetch_win) begin
      state_d = StRdIf;
    end else if (data_win && !bus.d_we) begin
      state_d = StRdD;
    end

    wait_cnt_d = '0;
    if (bus.if_req && !fetch_win) begin
      wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
    end
  end

  // State registers. The asynchronous reset drops any read that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StNone;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read data return. rdata is held at 0 unless its rvalid is high.
  always_comb begin
    bus.if_rvalid = (state_q == StRdIf);
    bus.d_rvalid  = (state_q == StRdD);
    bus.if_rdata  = bus.if_rvalid ? bus.memory_rd : 32'h0;
    bus.d_rdata   = bus.d_rvalid ? bus.memory_rd : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A cycle model predicts the grants and memory
// commands. Reads predicted by the model push the expected return onto a queue.
// The queue is popped on the following cycle and checked against rvalid/rdata.
module tb_mem_arbiter;

  localparam int unsigned MaxWait = 4;

  logic clk;
  logic rst_n;

  mem_arbiter_if ifc ();

  mem_arbiter #(
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct {
    bit          fetch;
    logic [31:0] data;
  } rd_t;

  rd_t         exp_q[$];
  int unsigned waitm;
  int          n_checks;
  int          n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_hash(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Memory model with one cycle of read latency
  always @(posedge clk) ifc.memory_rd <= mem_hash(ifc.memory_ra);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_if_gnt"}, 32'(ifc.if_gnt), 32'h0);
    check_eq({tag, "_d_gnt"}, 32'(ifc.d_gnt), 32'h0);
    check_eq({tag, "_if_rvalid"}, 32'(ifc.if_rvalid), 32'h0);
    check_eq({tag, "_d_rvalid"}, 32'(ifc.d_rvalid), 32'h0);
    check_eq({tag, "_if_rdata"}, ifc.if_rdata, 32'h0);
    check_eq({tag, "_d_rdata"}, ifc.d_rdata, 32'h0);
    check_eq({tag, "_wen"}, 32'(ifc.memory_wen), 32'h0);
    check_eq({tag, "_ra"}, ifc.memory_ra, 32'h0);
    check_eq({tag, "_wa"}, ifc.memory_wa, 32'h0);
    check_eq({tag, "_wd"}, ifc.memory_wd, 32'h0);
    check_eq({tag, "_func3"}, 32'(ifc.memory_func3), 32'h0);
  endtask

  // Drive one cycle of requests, then check the combinational outputs against the model.
  task automatic drive_and_check(input logic ifr, input logic [31:0] ia, input logic dr,
                                 input logic we, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic [2:0] df,
                                 output logic fw, output logic dw);
    logic [31:0] e_ra, e_wa, e_wd;
    logic [2:0]  e_f3;
    logic        e_wen;
    ifc.if_req  = ifr;
    ifc.if_addr = ia;
    ifc.d_req   = dr;
    ifc.d_we    = we;
    ifc.d_addr  = da;
    ifc.d_wdata = dwd;
    ifc.d_func3 = df;
    #1;
    fw    = ifr && (!dr || waitm == MaxWait);
    dw    = dr && !fw;
    e_wen = dw && we;
    e_ra  = fw ? ia : ((dw && !we) ? da : 32'h0);
    e_wa  = e_wen ? da : 32'h0;
    e_wd  = e_wen ? dwd : 32'h0;
    e_f3  = fw ? 3'b010 : (dw ? df : 3'b000);
    check_eq("if_gnt", 32'(ifc.if_gnt), 32'(fw));
    check_eq("d_gnt", 32'(ifc.d_gnt), 32'(dw));
    check_eq("memory_wen", 32'(ifc.memory_wen), 32'(e_wen));
    check_eq("memory_ra", ifc.memory_ra, e_ra);
    check_eq("memory_wa", ifc.memory_wa, e_wa);
    check_eq("memory_wd", ifc.memory_wd, e_wd);
    check_eq("memory_func3", 32'(ifc.memory_func3), 32'(e_f3));
    if (fw) exp_q.push_back('{fetch: 1'b1, data: mem_hash(ia)});
    else if (dw && !we) exp_q.push_back('{fetch: 1'b0, data: mem_hash(da)});
    if (ifr && !fw) waitm = (waitm == MaxWait) ? waitm : waitm + 1;
    else waitm = 0;
  endtask

  // Advance past the clock edge and check the returned read data.
  task automatic finish_cycle();
    rd_t e;
    bit  v;
    @(posedge clk);
    #1;
    v = exp_q.size() > 0;
    if (v) e = exp_q.pop_front();
    else e = '{fetch: 1'b0, data: 32'h0};
    check_eq("if_rvalid", 32'(ifc.if_rvalid), 32'(v && e.fetch));
    check_eq("if_rdata", ifc.if_rdata, (v && e.fetch) ? e.data : 32'h0);
    check_eq("d_rvalid", 32'(ifc.d_rvalid), 32'(v && !e.fetch));
    check_eq("d_rdata", ifc.d_rdata, (v && !e.fetch) ? e.data : 32'h0);
  endtask

  task automatic run_cycle(input logic ifr, input logic [31:0] ia, input logic dr,
                           input logic we, input logic [31:0] da, input logic [31:0] dwd,
                           input logic [2:0] df, output logic fw, output logic dw);
    drive_and_check(ifr, ia, dr, we, da, dwd, df, fw, dw);
    finish_cycle();
  endtask

  initial begin
    logic        fw, dw, pif, pd, pwe;
    logic [31:0] ia, da, dwd;
    logic [2:0]  df;
    int          first_if, wen_cycles;

    n_checks = 0;
    n_pass   = 0;
    waitm    = 0;
    rst_n    = 1'b0;
    ifc.if_req  = 1'b1;
    ifc.if_addr = 32'h100;
    ifc.d_req   = 1'b1;
    ifc.d_we    = 1'b1;
    ifc.d_addr  = 32'h200;
    ifc.d_wdata = 32'hFFFF_FFFF;
    ifc.d_func3 = 3'b111;

    // Reset held with requests asserted: every output must read 0
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    ifc.if_req = 1'b0;
    ifc.d_req  = 1'b0;
    #1 rst_n = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, fw, dw);

    // Lone fetch
    run_cycle(1, 32'h100, 0, 0, 0, 0, 0, fw, dw);

    // Store: wen for exactly one cycle, no rvalid after it
    wen_cycles = 0;
    drive_and_check(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 3'b010, fw, dw);
    wen_cycles += int'(ifc.memory_wen);
    finish_cycle();
    drive_and_check(0, 0, 0, 0, 0, 0, 0, fw, dw);
    wen_cycles += int'(ifc.memory_wen);
    finish_cycle();
    check_eq("store_wen_cycles", 32'(wen_cycles), 32'd1);

    // Contention: data wins MaxWait times, then fetch is forced through
    first_if = -1;
    for (int i = 0; i < 6; i++) begin
      drive_and_check(1, 32'h300, 1, 0, 32'h400 + 32'(i * 4), 0, 3'b100, fw, dw);
      if (ifc.if_gnt && first_if < 0) first_if = i;
      finish_cycle();
    end
    check_eq("contention_first_if", 32'(first_if), 32'(MaxWait));

    // Back-to-back: fetch then load, each rvalid carrying its own data
    run_cycle(1, 32'h500, 0, 0, 0, 0, 0, fw, dw);
    run_cycle(0, 0, 1, 0, 32'h604, 0, 3'b000, fw, dw);
    run_cycle(0, 0, 0, 0, 0, 0, 0, fw, dw);

    // Randomised traffic where requesters hold requests until granted
    pif = 1'b0;
    pd  = 1'b0;
    pwe = 1'b0;
    ia  = 0;
    da  = 0;
    dwd = 0;
    df  = 0;
    for (int i = 0; i < 80; i++) begin
      if (!pif) begin
        pif = 1'($urandom_range(0, 1));
        ia  = $urandom & 32'hFFFF_FFFC;
      end
      if (!pd) begin
        pd  = 1'($urandom_range(0, 2) != 0);
        pwe = 1'($urandom_range(0, 1));
        da  = $urandom;
        dwd = $urandom;
        df  = 3'($urandom_range(0, 7));
      end
      run_cycle(pif, ia, pd, pwe, da, dwd, df, fw, dw);
      if (fw) pif = 1'b0;
      if (dw) pd = 1'b0;
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0, fw, dw);

    // Reset mid-read: build up the wait counter, grant a load, then reset before the edge
    run_cycle(1, 32'h700, 1, 0, 32'h800, 0, 3'b010, fw, dw);
    run_cycle(1, 32'h700, 1, 0, 32'h804, 0, 3'b010, fw, dw);
    drive_and_check(1, 32'h700, 1, 0, 32'h808, 0, 3'b010, fw, dw);
    check_eq("pre_reset_d_gnt", 32'(dw), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    waitm = 0;
    finish_cycle();
    check_idle_outputs("held_reset");
    ifc.if_req = 1'b0;
    ifc.d_req  = 1'b0;
    rst_n      = 1'b1;

    // The wait counter must have restarted from 0
    first_if = -1;
    for (int i = 0; i < 6; i++) begin
      drive_and_check(1, 32'h900, 1, 0, 32'hA00 + 32'(i * 4), 0, 3'b001, fw, dw);
      if (ifc.if_gnt && first_if < 0) first_if = i;
      finish_cycle();
    end
    check_eq("post_reset_first_if", 32'(first_if), 32'(MaxWait));

    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, fw, dw);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
